hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard_reg_timer.sv | 26 ++
 rtl/hazard_scoreboard.sv | 65 ++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: values shared by the hazard scoreboard slice.
//   REG_LENGTH            register index width
//   DEF_LOAD_LAT          default load-to-use stall cycles with forwarding
//   DEF_WB_DIST           default issue-to-register-file-write distance
//   br_cond_e             branch condition codes
//   sb_cnt_width()        width of one per-register down-counter
package hazard_scoreboard_pkg;

  localparam int REG_LENGTH   = 5;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_WB_DIST  = 3;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd4,
    BR_GE  = 3'd5,
    BR_LTU = 3'd6,
    BR_GEU = 3'd7
  } br_cond_e;

  // Counter must hold the largest latency ever loaded.
  function automatic int sb_cnt_width(input int load_lat, input int wb_dist);
    int m;
    m = (load_lat + 1 > wb_dist) ? load_lat + 1 : wb_dist;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage issue bus into the scoreboard.
//   master: drives the decoded instruction (sources, destination, class,
//           flush) and observes stall.
//   slave : the scoreboard; returns stall combinationally.
interface hazard_scoreboard_if #(
  parameter int REG_W = hazard_scoreboard_pkg::REG_LENGTH
);
  logic             issue_valid;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             src2_used;
  logic [REG_W-1:0] dst;
  logic             dst_wen;
  logic             is_load;
  logic             is_branch;
  logic             flush;
  logic             stall;

  modport master (
    output issue_valid, src1, src2, src2_used, dst, dst_wen, is_load,
           is_branch, flush,
    input  stall
  );

  modport slave (
    input  issue_valid, src1, src2, src2_used, dst, dst_wen, is_load,
           is_branch, flush,
    output stall
  );
endinterface

// File: rtl/hazard_scoreboard_reg_timer.sv
// hazard_reg_timer: busy timer of one architectural register.
//   clk, rst (async, active-low)
//   load/lat : start counting down from lat (wins over the decrement)
//   nz       : counter nonzero
//   gt1      : counter greater than one
module hazard_reg_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] lat,
  output logic          nz,
  output logic          gt1
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt <= '0;
    else if (load)      cnt <= lat;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign nz  = (cnt != '0);
  assign gt1 = (cnt > CW'(1));
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register RAW hazard tracking for the ID stage.
//   clk, rst        clock; asynchronous active-low reset
//   sb (slave)      issue bus; sb.stall is combinational
//   stall_count     saturating count of stalled cycles (registered)
// Build option: HAZARD_FWD_EN selects forwarding mode (loads busy for
// LOAD_LAT+1, other writers for 1; branches need the value one cycle earlier
// than other consumers). Without it every writer is busy for WB_DIST.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W    = REG_LENGTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int WB_DIST  = DEF_WB_DIST,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_scoreboard_if.slave sb,
  output logic [CNT_W-1:0] stall_count
);
  localparam int NUM_REGS = 2 ** REG_W;
  localparam int CW       = sb_cnt_width(LOAD_LAT, WB_DIST);

  logic [NUM_REGS-1:0] nz, gt1, blk;
  logic [CW-1:0]       lat;
  logic                accept;

  // r0 is hardwired, never tracked.
  assign nz[0]  = 1'b0;
  assign gt1[0] = 1'b0;

`ifdef HAZARD_FWD_EN
  assign lat = sb.is_load ? CW'(LOAD_LAT + 1) : CW'(1);
  // Counter at 1 means the value sits on the bypass network: fine for ALU
  // consumers, too late for the branch comparator.
  assign blk = sb.is_branch ? nz : gt1;
`else
  logic unused_cls;
  assign unused_cls = sb.is_load ^ sb.is_branch;
  assign lat = CW'(WB_DIST);
  // Register file is write-first: in the cycle the counter reads 1 the write
  // lands and the reader in ID already sees it.
  assign blk = gt1;
`endif

  assign sb.stall = sb.issue_valid & ~sb.flush &
                    (blk[sb.src1] | (sb.src2_used & blk[sb.src2]));
  assign accept   = sb.issue_valid & ~sb.stall & ~sb.flush;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_reg_timer #(.CW(CW)) u_tmr (
      .clk  (clk),
      .rst  (rst),
      .load (accept & sb.dst_wen & (sb.dst == REG_W'(r))),
      .lat  (lat),
      .nz   (nz[r]),
      .gt1  (gt1[r])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   stall_count <= '0;
    else if (sb.stall && (stall_count != '1))   stall_count <= stall_count + 1'b1;
  end
endmodule
